freq_divider_prog: RTL and testbench

- Parametrised, programmable clock divider. Successor to the fixed 8-bit divider.
- Generates a registered divided clock `clk_out` from `clk_in` with:
  - configurable width;
  - 50%-style or programmable-high-time duty mode;
  - glitch-free configuration updates, applied only at period boundaries;
  - a graceful enable/stop;
  - a per-period tick.
- Sits in clock/timing generation, feeding slow-clock enables and observation outputs.

---
 rtl/freq_divider_prog.sv | 184 ++++++++++++++++++
 tb/tb_freq_divider_prog.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_divider_prog.sv
// Programmable clock divider: registered divided clock with auto or programmable duty,
// configuration changes taken only at period boundaries, graceful stop and a per-period tick.
module freq_divider_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic             cfg_mode,
  output logic             clk_out,
  output logic             period_tick,
  output logic             running,
  output logic             cfg_pending
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ZERO    = WIDTH'(0);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0] C_DEF_DIV = WIDTH'(DEFAULT_DIV);

  // A divisor of 1 cannot produce a clock, so it is run as 2.
  function automatic logic [WIDTH-1:0] f_div_act(input logic [WIDTH-1:0] div);
    f_div_act = (div == C_ONE) ? C_TWO : div;
  endfunction

  function automatic logic [WIDTH-1:0] f_high_act(input logic [WIDTH-1:0] div,
                                                  input logic [WIDTH-1:0] high,
                                                  input logic             mode);
    logic [WIDTH-1:0] d;
    d = f_div_act(div);
    if (!mode) begin
      f_high_act = d >> 1;
    end else if (high == C_ZERO) begin
      f_high_act = C_ONE;
    end else if (high >= d) begin
      f_high_act = d - C_ONE;
    end else begin
      f_high_act = high;
    end
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_running;
  logic             r_pend;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_high;
  logic             r_mode;
  logic [WIDTH-1:0] r_pdiv;
  logic [WIDTH-1:0] r_phigh;
  logic             r_pmode;

  logic [WIDTH-1:0] w_div_act;
  logic             w_last;
  logic             w_apply;
  logic [WIDTH-1:0] w_div_new;
  logic [WIDTH-1:0] w_high_raw_new;
  logic             w_mode_new;
  logic [WIDTH-1:0] w_high_new;
  logic             w_clk_nxt;
  logic             w_tick_nxt;
  logic             w_run_nxt;
  logic             w_pend_nxt;

  // The config seen by the next cycle: pending values replace the active ones at a boundary or in IDLE.
  always_comb begin
    w_div_act      = f_div_act(r_div);
    w_last         = (r_cnt == (w_div_act - C_ONE));
    w_apply        = r_pend && ((r_state == S_IDLE) || w_last);
    w_div_new      = w_apply ? r_pdiv  : r_div;
    w_high_raw_new = w_apply ? r_phigh : r_high;
    w_mode_new     = w_apply ? r_pmode : r_mode;
    w_high_new     = f_high_act(w_div_new, w_high_raw_new, w_mode_new);
  end

  // State and counter registers, plus the registered outputs aligned with the counter.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= C_ZERO;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
      r_running <= w_run_nxt;
    end
  end

  // Next state and count; a stop request landing on the last cycle ends the period directly.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = C_ZERO;
        if (en && (w_div_new != C_ZERO)) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN, S_DRAIN: begin
        if (w_last) begin
          w_cnt_nxt = C_ZERO;
          if ((w_div_new != C_ZERO) && en) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt   = r_cnt + C_ONE;
          w_state_nxt = en ? S_RUN : S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = C_ZERO;
      end
    endcase
  end

  // Output values for the coming cycle.
  always_comb begin
    w_run_nxt  = (w_state_nxt != S_IDLE);
    w_clk_nxt  = w_run_nxt && (w_cnt_nxt < w_high_new);
    w_tick_nxt = w_run_nxt && (w_cnt_nxt == C_ZERO);
    if (cfg_wr) begin
      w_pend_nxt = 1'b1;
    end else if (w_apply) begin
      w_pend_nxt = 1'b0;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // Pending and active configuration registers; a write racing an apply becomes the new pending.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_div   <= C_DEF_DIV;
      r_high  <= C_ZERO;
      r_mode  <= 1'b0;
      r_pdiv  <= C_ZERO;
      r_phigh <= C_ZERO;
      r_pmode <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_apply) begin
        r_div  <= r_pdiv;
        r_high <= r_phigh;
        r_mode <= r_pmode;
      end
      if (cfg_wr) begin
        r_pdiv  <= cfg_div;
        r_phigh <= cfg_high;
        r_pmode <= cfg_mode;
      end
    end
  end

  assign clk_out     = r_clk_out;
  assign period_tick = r_tick;
  assign running     = r_running;
  assign cfg_pending = r_pend;

endmodule

// File: tb/tb_freq_divider_prog.sv
// Directed bench for freq_divider_prog: table of divider configurations plus hand-written
// sequences for mid-period reconfiguration, drain, re-enable, async reset and div=0 stop.
module tb_freq_divider_prog;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_wr;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic       cfg_mode;
  logic       clk_out;
  logic       period_tick;
  logic       running;
  logic       cfg_pending;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       wr;
    logic [7:0] div;
    logic [7:0] high;
    logic       mode;
    int         exp_high;
    int         exp_per;
  } vec_t;

  vec_t vecs[8];

  always #5 clk_in = ~clk_in;

  freq_divider_prog #(.WIDTH(8), .DEFAULT_DIV(8)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .cfg_wr      (cfg_wr),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .cfg_mode    (cfg_mode),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .running     (running),
    .cfg_pending (cfg_pending)
  );

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic e_clk, input logic e_tick,
                         input logic e_run, input logic e_pend);
    chk({name, ".clk_out"}, clk_out, e_clk);
    chk({name, ".tick"}, period_tick, e_tick);
    chk({name, ".running"}, running, e_run);
    chk({name, ".pending"}, cfg_pending, e_pend);
  endtask

  // Checks one full period starting at its cnt=0 cycle; leaves the bench at the next period start.
  task automatic check_period(input int p, input int h, input string name);
    for (int c = 0; c < p; c++) begin
      chk($sformatf("%s.c%0d.clk_out", name, c), clk_out, (c < h));
      chk($sformatf("%s.c%0d.tick", name, c), period_tick, (c == 0));
      chk($sformatf("%s.c%0d.running", name, c), running, 1'b1);
      step();
    end
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    en       = 1'b0;
    cfg_wr   = 1'b0;
    cfg_div  = 8'd0;
    cfg_high = 8'd0;
    cfg_mode = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [7:0] d, input logic [7:0] h, input logic m);
    cfg_wr   = 1'b1;
    cfg_div  = d;
    cfg_high = h;
    cfg_mode = m;
    step();
    cfg_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_wr = 1'b0; cfg_div = 8'd0; cfg_high = 8'd0; cfg_mode = 1'b0;

    vecs[0] = '{1'b0, 8'd8,  8'd0,  1'b0, 4, 8};
    vecs[1] = '{1'b1, 8'd5,  8'd0,  1'b0, 2, 5};
    vecs[2] = '{1'b1, 8'd1,  8'd0,  1'b0, 1, 2};
    vecs[3] = '{1'b1, 8'd10, 8'd3,  1'b1, 3, 10};
    vecs[4] = '{1'b1, 8'd10, 8'd0,  1'b1, 1, 10};
    vecs[5] = '{1'b1, 8'd10, 8'd12, 1'b1, 9, 10};
    vecs[6] = '{1'b1, 8'd7,  8'd0,  1'b0, 3, 7};
    vecs[7] = '{1'b1, 8'd2,  8'd5,  1'b1, 1, 2};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      chk_out($sformatf("v%0d.reset", v), 1'b0, 1'b0, 1'b0, 1'b0);
      if (vecs[v].wr) begin
        write_cfg(vecs[v].div, vecs[v].high, vecs[v].mode);
        chk($sformatf("v%0d.pend_set", v), cfg_pending, 1'b1);
        step();
        chk($sformatf("v%0d.pend_clr", v), cfg_pending, 1'b0);
      end
      en = 1'b1;
      step();
      check_period(vecs[v].exp_per, vecs[v].exp_high, $sformatf("v%0d.p1", v));
      check_period(vecs[v].exp_per, vecs[v].exp_high, $sformatf("v%0d.p2", v));
    end

    // Mid-period change from 8 to 4 written at cnt=3
    do_reset();
    en = 1'b1;
    step();
    chk_out("A.c0", 1'b1, 1'b1, 1'b1, 1'b0);
    step(); step(); step();
    write_cfg(8'd4, 8'd0, 1'b0);
    chk_out("A.c4", 1'b0, 1'b0, 1'b1, 1'b1);
    step(); step(); step();
    chk_out("A.c7", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("A.pend_clr", cfg_pending, 1'b0);
    check_period(4, 2, "A.p4a");
    check_period(4, 2, "A.p4b");

    // Two writes before the boundary: last one wins
    write_cfg(8'd6, 8'd0, 1'b0);
    chk_out("B.c1", 1'b1, 1'b0, 1'b1, 1'b1);
    write_cfg(8'd3, 8'd0, 1'b0);
    chk_out("B.c2", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk_out("B.c3", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("B.pend_clr", cfg_pending, 1'b0);
    check_period(3, 1, "B.p3a");
    check_period(3, 1, "B.p3b");

    // Stop at cnt=2: period completes in DRAIN, then IDLE
    do_reset();
    en = 1'b1;
    step(); step(); step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("C.drain%0d", i), ((3 + i) < 4), 1'b0, 1'b1, 1'b0);
    end
    step();
    chk_out("C.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("C.idle2", 1'b0, 1'b0, 1'b0, 1'b0);

    // Re-enable during DRAIN: no gap
    do_reset();
    en = 1'b1;
    step(); step(); step();
    en = 1'b0;
    step();
    chk("D.c3.running", running, 1'b1);
    step(); step();
    en = 1'b1;
    step();
    chk_out("D.c6", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); step();
    chk_out("D.c0", 1'b1, 1'b1, 1'b1, 1'b0);
    check_period(8, 4, "D.p8");

    // Async reset mid-high phase drops pending config
    do_reset();
    en = 1'b1;
    step();
    write_cfg(8'd3, 8'd0, 1'b0);
    chk_out("E.pre", 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("E.async", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("E.held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk("E.pend_dropped", cfg_pending, 1'b0);
    check_period(8, 4, "E.p8");

    // div=0 while running: stop at next boundary, stay idle with en=1
    write_cfg(8'd0, 8'd0, 1'b0);
    step(); step(); step(); step(); step(); step();
    chk_out("F.c7", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk_out("F.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("F.idle2", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
